// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the convolution engine slice
// (conv_sequencer, conv2d, buffer).
package conv_pkg;

  localparam int unsigned NO_OF_ROWS        = 5;
  localparam int unsigned NO_OF_COLUMNS     = 5;
  localparam int unsigned NO_OF_PIXELS      = NO_OF_ROWS * NO_OF_COLUMNS;

  localparam int unsigned ADDR_WIDTH        = 17;
  localparam int unsigned DATA_WIDTH        = 12;
  localparam int unsigned FRAME_COUNT_WIDTH = 8;

  // Sequencer states; S_ERROR is only reachable with CONV_SEQ_TIMEOUT_EN.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ARM    = 3'd2,
    S_KICK   = 3'd3,
    S_RUN    = 3'd4,
    S_FINISH = 3'd5,
    S_ERROR  = 3'd6
  } seq_state_t;

endpackage

// File: rtl/conv_watchdog.sv
// Loadable down-counting watchdog with clear, enable and terminal count.
// Only built when CONV_SEQ_TIMEOUT_EN is defined (its sole user is the
// sequencer's RUN timeout).
`ifdef CONV_SEQ_TIMEOUT_EN
module conv_watchdog #(
  parameter int unsigned CountBitWidth = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     load,
  input  logic [CountBitWidth-1:0] load_value,
  input  logic                     en,
  output logic                     tc
);

  logic [CountBitWidth-1:0] cnt;

  // Count down while enabled, parking at zero; load takes priority over counting.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CountBitWidth'(1);
    end
  end

  assign tc = en && (cnt == '0);

endmodule
`endif

// File: rtl/conv_sequencer.sv
// Frame-level controller for the conv2d engine and its single-port image RAM:
// loads a frame from the host stream, resets and kicks the engine, hands the
// RAM port to the engine, forwards results and counts completed frames.
// Optional RUN watchdog with ERROR state: define CONV_SEQ_TIMEOUT_EN.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned AddressBitWidth = ADDR_WIDTH,
  parameter int unsigned DataBitWidth    = DATA_WIDTH,
  parameter int unsigned NoOfPixels      = NO_OF_PIXELS,
  parameter int unsigned TimeoutCycles   = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go,
  input  logic                       host_valid,
  input  logic [DataBitWidth-1:0]    host_data,
  output logic                       host_ready,
  output logic [AddressBitWidth-1:0] mem_addr,
  output logic                       mem_we,
  output logic [DataBitWidth-1:0]    mem_wdata,
  input  logic [AddressBitWidth-1:0] conv_read_addr,
  input  logic [DataBitWidth-1:0]    conv_dout,
  input  logic                       conv_ready,
  output logic                       conv_rst,
  output logic                       conv_start,
  output logic                       res_valid,
  output logic [DataBitWidth-1:0]    res_data,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 frame_count,
  output logic                       error
);

  seq_state_t                 state;
  seq_state_t                 state_next;
  logic [AddressBitWidth-1:0] load_cnt;
  logic                       accept;
  logic                       last_accept;

  assign accept      = (state == S_LOAD) && host_valid;
  assign last_accept = accept && (load_cnt == AddressBitWidth'(NoOfPixels - 1));

`ifdef CONV_SEQ_TIMEOUT_EN
  localparam int unsigned WdBits = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  logic wd_tc;

  // Loaded during KICK so the terminal count lands on the last allowed RUN cycle.
  conv_watchdog #(
    .CountBitWidth(WdBits)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr       (state == S_IDLE),
    .load      (state == S_KICK),
    .load_value(WdBits'(TimeoutCycles - 1)),
    .en        (state == S_RUN),
    .tc        (wd_tc)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TimeoutCycles;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and combinational RAM/engine control.
  always_comb begin
    state_next = state;
    host_ready = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    conv_rst   = rst;
    conv_start = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) state_next = S_LOAD;
      end
      S_LOAD: begin
        host_ready = 1'b1;
        mem_addr   = load_cnt;
        mem_we     = host_valid;
        mem_wdata  = host_data;
        if (last_accept) state_next = S_ARM;
      end
      S_ARM: begin
        conv_rst   = 1'b1;
        state_next = S_KICK;
      end
      S_KICK: begin
        conv_start = 1'b1;
        state_next = S_RUN;
      end
      S_RUN: begin
        mem_addr = conv_read_addr;
        if (conv_ready) begin
          state_next = S_FINISH;
`ifdef CONV_SEQ_TIMEOUT_EN
        end else if (wd_tc) begin
          state_next = S_ERROR;
`endif
        end
      end
      S_FINISH: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
`ifdef CONV_SEQ_TIMEOUT_EN
      S_ERROR: begin
        conv_rst = 1'b1;
        if (go) state_next = S_IDLE;
      end
`endif
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Load address counter: cleared on frame request, advanced per accepted pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt <= '0;
    end else if ((state == S_IDLE) && go) begin
      load_cnt <= '0;
    end else if (accept) begin
      load_cnt <= load_cnt + AddressBitWidth'(1);
    end
  end

  // Registered status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      frame_count <= '0;
    end else begin
      busy <= (state_next != S_IDLE);
      // Valid only on RUN cycles preceded by another RUN cycle (RAM read latency).
      res_valid <= (state == S_RUN) && (state_next == S_RUN);
      if (state == S_RUN) res_data <= conv_dout;
      if (state == S_FINISH) frame_count <= frame_count + 8'd1;
    end
  end

`ifdef CONV_SEQ_TIMEOUT_EN
  // Sticky error: held while in ERROR, dropped when go returns us to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      error <= 1'b0;
    end else begin
      error <= (state_next == S_ERROR);
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: table-driven frames, randomized
// frames, mid-frame reset, frame counter wrap and (with CONV_SEQ_TIMEOUT_EN)
// the RUN watchdog.
module tb_conv_sequencer;

  localparam int unsigned AW = 17;
  localparam int unsigned DW = 12;
  localparam int unsigned NP = 25;
  localparam int unsigned TO = 16;

  logic          clk;
  logic          rst;
  logic          go;
  logic          host_valid;
  logic [DW-1:0] host_data;
  logic          host_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [AW-1:0] conv_read_addr;
  logic [DW-1:0] conv_dout;
  logic          conv_ready;
  logic          conv_rst;
  logic          conv_start;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          busy;
  logic          done;
  logic [7:0]    frame_count;
  logic          error;

  conv_sequencer #(
    .AddressBitWidth(AW),
    .DataBitWidth   (DW),
    .NoOfPixels     (NP),
    .TimeoutCycles  (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .go            (go),
    .host_valid    (host_valid),
    .host_data     (host_data),
    .host_ready    (host_ready),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .conv_read_addr(conv_read_addr),
    .conv_dout     (conv_dout),
    .conv_ready    (conv_ready),
    .conv_rst      (conv_rst),
    .conv_start    (conv_start),
    .res_valid     (res_valid),
    .res_data      (res_data),
    .busy          (busy),
    .done          (done),
    .frame_count   (frame_count),
    .error         (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int exp_fc   = 0;

  typedef struct {
    int gap_mode;       // 0 back-to-back, 1 every other cycle, 2 random
    int run_len;        // RUN cycle on which the engine raises ready
    bit go_with_valid;  // host_valid alongside go in IDLE
    bit go_noise;       // random go pulses after the frame started
    int exp_writes;
    int exp_rv;
    int exp_done;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_conv_rst"},    conv_rst, 1);
    chk({tag, "_host_ready"},  host_ready, 0);
    chk({tag, "_mem_addr"},    mem_addr, 0);
    chk({tag, "_mem_we"},      mem_we, 0);
    chk({tag, "_mem_wdata"},   mem_wdata, 0);
    chk({tag, "_conv_start"},  conv_start, 0);
    chk({tag, "_res_valid"},   res_valid, 0);
    chk({tag, "_res_data"},    res_data, 0);
    chk({tag, "_busy"},        busy, 0);
    chk({tag, "_done"},        done, 0);
    chk({tag, "_frame_count"}, frame_count, 0);
    chk({tag, "_error"},       error, 0);
  endtask

  // IDLE go cycle, pixel load, ARM and KICK; returns RAM writes observed.
  task automatic load_frame(input int gap_mode, input bit go_with_valid,
                            input bit go_noise, output int n_wr);
    int acc;
    int cyc;
    bit v;
    n_wr = 0;
    go         = 1'b1;
    host_valid = go_with_valid;
    host_data  = DW'($urandom);
    to_sample();
    chk("idle_busy", busy, 0);
    chk("idle_host_ready", host_ready, 0);
    chk("idle_mem_we", mem_we, 0);
    chk("idle_mem_addr", mem_addr, 0);
    chk("idle_conv_rst", conv_rst, 0);
    chk("idle_done", done, 0);
    chk("idle_error", error, 0);
    chk("idle_frame_count", frame_count, 32'(exp_fc));
    if (mem_we) n_wr++;
    to_drive();
    acc = 0;
    cyc = 0;
    while (acc < int'(NP) && cyc < 400) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 1;
        default: v = $urandom_range(0, 1) == 1;
      endcase
      go         = go_noise ? ($urandom_range(0, 1) == 1) : 1'b0;
      host_valid = v;
      host_data  = DW'($urandom);
      to_sample();
      chk("load_host_ready", host_ready, 1);
      chk("load_mem_we", mem_we, v);
      chk("load_busy", busy, 1);
      if (v) begin
        chk("load_mem_addr", mem_addr, 32'(acc));
        chk("load_mem_wdata", mem_wdata, host_data);
        acc++;
      end
      if (mem_we) n_wr++;
      cyc++;
      to_drive();
    end
    if (acc < int'(NP)) chk("load_cycle_budget", 32'(acc), 32'(NP));
    go         = 1'b0;
    host_valid = $urandom_range(0, 1) == 1;
    to_sample();
    chk("arm_conv_rst", conv_rst, 1);
    chk("arm_conv_start", conv_start, 0);
    chk("arm_host_ready", host_ready, 0);
    chk("arm_mem_we", mem_we, 0);
    chk("arm_mem_addr", mem_addr, 0);
    if (mem_we) n_wr++;
    to_drive();
    conv_ready = 1'b0;  // engine was reset by ARM
    to_sample();
    chk("kick_conv_start", conv_start, 1);
    chk("kick_conv_rst", conv_rst, 0);
    chk("kick_mem_we", mem_we, 0);
    if (mem_we) n_wr++;
    to_drive();
  endtask

  // RUN until the engine reports ready on cycle run_len, then FINISH.
  task automatic run_phase(input int run_len, input bit go_noise,
                           output int n_rv, output int n_done);
    logic [DW-1:0] prev;
    n_rv   = 0;
    n_done = 0;
    prev   = '0;
    for (int k = 1; k <= run_len; k++) begin
      conv_read_addr = AW'($urandom);
      conv_dout      = DW'($urandom);
      conv_ready     = (k == run_len);
      go             = go_noise ? ($urandom_range(0, 1) == 1) : 1'b0;
      host_valid     = $urandom_range(0, 1) == 1;
      to_sample();
      chk("run_mem_addr", mem_addr, conv_read_addr);
      chk("run_mem_we", mem_we, 0);
      chk("run_res_valid", res_valid, k >= 2);
      if (k >= 2) chk("run_res_data", res_data, prev);
      chk("run_busy", busy, 1);
      if (res_valid) n_rv++;
      if (done) n_done++;
      prev = conv_dout;
      to_drive();
    end
    go = 1'b0;
    to_sample();
    chk("fin_done", done, 1);
    chk("fin_res_valid", res_valid, 0);
    chk("fin_res_data", res_data, prev);
    chk("fin_frame_count", frame_count, 32'(exp_fc));
    chk("fin_mem_we", mem_we, 0);
    if (done) n_done++;
    exp_fc = (exp_fc + 1) % 256;
    to_drive();
  endtask

  initial begin
    vec_t tbl[6];
    int n_wr;
    int n_rv;
    int n_done;

    tbl[0] = '{0,  1, 1'b0, 1'b0, 25,  0, 1};
    tbl[1] = '{0,  4, 1'b1, 1'b0, 25,  3, 1};
    tbl[2] = '{1,  6, 1'b0, 1'b0, 25,  5, 1};
    tbl[3] = '{2,  8, 1'b1, 1'b1, 25,  7, 1};
    tbl[4] = '{1, 12, 1'b1, 1'b1, 25, 11, 1};
    tbl[5] = '{2,  2, 1'b0, 1'b1, 25,  1, 1};

    // Reset held for two cycles with noisy inputs.
    rst            = 1'b1;
    go             = 1'b1;
    host_valid     = 1'b1;
    host_data      = '1;
    conv_read_addr = '1;
    conv_dout      = '1;
    conv_ready     = 1'b1;
    to_drive();
    to_sample();
    check_reset_values("rst1");
    to_drive();
    to_sample();
    check_reset_values("rst2");
    to_drive();
    rst        = 1'b0;
    go         = 1'b0;
    host_valid = 1'b0;
    to_sample();
    chk("post_rst_conv_rst", conv_rst, 0);
    chk("post_rst_busy", busy, 0);
    to_drive();

    // Table-driven frames.
    for (int i = 0; i < 6; i++) begin
      load_frame(tbl[i].gap_mode, tbl[i].go_with_valid, tbl[i].go_noise, n_wr);
      run_phase(tbl[i].run_len, tbl[i].go_noise, n_rv, n_done);
      chk($sformatf("tbl%0d_writes", i), 32'(n_wr), 32'(tbl[i].exp_writes));
      chk($sformatf("tbl%0d_res_valid", i), 32'(n_rv), 32'(tbl[i].exp_rv));
      chk($sformatf("tbl%0d_done", i), 32'(n_done), 32'(tbl[i].exp_done));
    end

    // Randomized frames.
    for (int i = 0; i < 10; i++) begin
      int gm;
      int rl;
      bit gn;
      gm = $urandom_range(0, 2);
      rl = $urandom_range(1, 15);
      gn = $urandom_range(0, 1) == 1;
      load_frame(gm, gn, gn, n_wr);
      run_phase(rl, gn, n_rv, n_done);
      chk($sformatf("rnd%0d_writes", i), 32'(n_wr), 32'(NP));
      chk($sformatf("rnd%0d_res_valid", i), 32'(n_rv), 32'(rl - 1));
      chk($sformatf("rnd%0d_done", i), 32'(n_done), 1);
    end

`ifdef CONV_SEQ_TIMEOUT_EN
    // Engine never completes: watchdog must park the sequencer in ERROR.
    load_frame(0, 1'b0, 1'b0, n_wr);
    for (int k = 1; k <= int'(TO); k++) begin
      conv_read_addr = AW'($urandom);
      conv_ready     = 1'b0;
      to_sample();
      chk("to_run_mem_addr", mem_addr, conv_read_addr);
      chk("to_run_error", error, 0);
      chk("to_run_done", done, 0);
      to_drive();
    end
    for (int k = 0; k < 4; k++) begin
      to_sample();
      chk("err_error", error, 1);
      chk("err_conv_rst", conv_rst, 1);
      chk("err_res_valid", res_valid, 0);
      chk("err_done", done, 0);
      chk("err_busy", busy, 1);
      chk("err_frame_count", frame_count, 32'(exp_fc));
      to_drive();
    end
    go = 1'b1;
    to_sample();
    chk("err_go_error", error, 1);
    to_drive();
    go = 1'b0;
    to_sample();
    chk("err_exit_error", error, 0);
    chk("err_exit_busy", busy, 0);
    chk("err_exit_conv_rst", conv_rst, 0);
    chk("err_exit_frame_count", frame_count, 32'(exp_fc));
    to_drive();
`endif

    // Reset in the middle of a load, then a complete frame from scratch.
    go = 1'b1;
    to_drive();
    go = 1'b0;
    for (int k = 0; k < 10; k++) begin
      host_valid = 1'b1;
      host_data  = DW'($urandom);
      to_drive();
    end
    rst = 1'b1;
    to_drive();
    to_sample();
    check_reset_values("midrst");
    to_drive();
    rst        = 1'b0;
    host_valid = 1'b0;
    exp_fc     = 0;
    load_frame(0, 1'b0, 1'b0, n_wr);
    run_phase(3, 1'b0, n_rv, n_done);
    chk("midrst_writes", 32'(n_wr), 32'(NP));
    chk("midrst_done", 32'(n_done), 1);

    // Frame counter wrap after 256 frames since reset.
    for (int i = 1; i < 256; i++) begin
      load_frame(0, 1'b0, 1'b0, n_wr);
      run_phase(1, 1'b0, n_rv, n_done);
    end
    to_sample();
    chk("wrap_frame_count", frame_count, 0);
    chk("wrap_busy", busy, 0);
    to_drive();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
